// File: rtl/ksa_seq_multiplier_pkg.sv
// Shared types and constants for the sequential Kogge-Stone shift-add multiplier.
package ksa_mul_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] LAST_ITER = 5'd15;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/ksa_seq_multiplier_adder.sv
// 16-bit Kogge-Stone parallel-prefix adder, no carry-in, 17-bit sum (S[16] is carry-out).
module koggeStoneAdder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [16:0] S
);

  localparam int N      = 16;
  localparam int LEVELS = 4;

  logic [LEVELS:0][N-1:0] g;
  logic [LEVELS:0][N-1:0] p;

  assign g[0] = A & B;
  assign p[0] = A ^ B;

  // Each level doubles the span of the group generate/propagate terms.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= D) begin : g_merge
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-D]);
        assign p[l+1][i] = p[l][i] & p[l][i-D];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end

  assign S[0]     = p[0][0];
  assign S[N-1:1] = p[0][N-1:1] ^ g[LEVELS][N-2:0];
  assign S[N]     = g[LEVELS][N-1];

endmodule

// File: rtl/ksa_seq_multiplier.sv
// 16x16 unsigned shift-add multiplier iterating one Kogge-Stone adder per multiplier bit.
module ksa_seq_multiplier
  import ksa_mul_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_e           state_q;
  logic [OP_W-1:0]  hi_q, lo_q, mcand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OP_W:0]    add_s;
  logic [OP_W:0]    sum17;

  koggeStoneAdder u_ksa (
    .A (hi_q),
    .B (mcand_q),
    .S (add_s)
  );

  // Skip the add when the current multiplier bit is clear; the shift still happens.
  assign sum17 = lo_q[0] ? add_s : {1'b0, hi_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            mcand_q <= a;
            hi_q    <= '0;
            cnt_q   <= '0;
            if (ZERO_BYPASS && ((a == '0) || (b == '0))) begin
              lo_q    <= '0;
              state_q <= DONE;
            end else begin
              lo_q    <= b;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          hi_q  <= sum17[OP_W:1];
          lo_q  <= {sum17[0], lo_q[OP_W-1:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) state_q <= DONE;
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign product     = {hi_q, lo_q};

endmodule

// File: tb/tb_ksa_seq_multiplier.sv
// Randomized self-checking bench: bypass and non-bypass instances share stimulus.
module tb_ksa_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [15:0] a = '0, b = '0;

  logic        sr0, rv0, bz0, sr1, rv1, bz1;
  logic [31:0] p0, p1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ksa_seq_multiplier #(.ZERO_BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr0),
    .a(a), .b(b), .res_valid(rv0), .res_ready(res_ready), .product(p0), .busy(bz0)
  );

  ksa_seq_multiplier #(.ZERO_BYPASS(1'b0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr1),
    .a(a), .b(b), .res_valid(rv1), .res_ready(res_ready), .product(p1), .busy(bz1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Latency is counted in edges from the edge after which the request is presented,
  // so the accept is edge 1, a bypassed result shows at 1 and an iterated one at 17.
  function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y, input bit byp);
    return (byp && (x == 0 || y == 0)) ? 1 : 17;
  endfunction

  task automatic op(input logic [15:0] x, input logic [15:0] y, input string tag);
    int l0 = 0, l1 = 0;
    logic [31:0] q0 = '0, q1 = '0;
    logic [31:0] exp = 32'(x) * 32'(y);
    @(posedge clk); #1;
    chk({tag, ".rdy"}, {31'd0, sr0 & sr1}, 32'd1);
    a = x; b = y; start_valid = 1'b1; res_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) start_valid = 1'b0;
      if (rv0 && l0 == 0) begin l0 = c; q0 = p0; end
      if (rv1 && l1 == 0) begin l1 = c; q1 = p1; end
      if (l0 != 0 && l1 != 0) break;
    end
    chk({tag, ".prod_byp"}, q0, exp);
    chk({tag, ".prod_nob"}, q1, exp);
    chk({tag, ".lat_byp"}, 32'(l0), 32'(ref_lat(x, y, 1'b1)));
    chk({tag, ".lat_nob"}, 32'(l1), 32'(ref_lat(x, y, 1'b0)));
  endtask

  initial begin
    int lat;
    logic [15:0] x, y;

    #12;
    chk("rst.ready", {31'd0, sr0}, 32'd1);
    chk("rst.valid", {31'd0, rv0}, 32'd0);
    chk("rst.busy", {31'd0, bz0}, 32'd0);
    chk("rst.prod", p0, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    op(16'd3, 16'd5, "3x5");
    op(16'hFFFF, 16'hFFFF, "ffffxffff");
    op(16'h0000, 16'h1234, "zero_a");
    op(16'hBEEF, 16'h0000, "zero_b");

    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom); y = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) x = '0; else y = '0;
      end
      op(x, y, $sformatf("rand%0d", i));
    end

    // Held result under back-pressure, with competing requests during RUN and DONE.
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h5678; start_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'h0002;
    lat = 0;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 6) chk("hold.run_rdy", {31'd0, sr0}, 32'd0);
      if (rv0) begin lat = c; break; end
    end
    chk("hold.lat", 32'(lat), 32'd17);
    for (int k = 0; k < 5; k++) begin
      chk("hold.prod", p0, 32'h06260060);
      chk("hold.valid", {31'd0, rv0}, 32'd1);
      chk("hold.done_rdy", {31'd0, sr0}, 32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold.idle_rdy", {31'd0, sr0}, 32'd1);
    chk("hold.idle_valid", {31'd0, rv0}, 32'd0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("b2b.accepted", {31'd0, bz0}, 32'd1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (rv0) begin lat = c; break; end
    end
    chk("b2b.lat", 32'(lat), 32'd16);
    chk("b2b.prod", p0, 32'h0001FFFE);

    // Asynchronous reset in the middle of an iteration discards the operation.
    @(posedge clk); #1;
    a = 16'hABCD; b = 16'h1357; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst.ready", {31'd0, sr0}, 32'd1);
    chk("mrst.valid", {31'd0, rv0}, 32'd0);
    chk("mrst.busy", {31'd0, bz0}, 32'd0);
    chk("mrst.prod", p0, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    op(16'd7, 16'd9, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
